feature_serializer: RTL

Frame-to-stream converter for the audio-processing path. It captures one parallel feature frame of NN_ARRAY_WIDTH words and emits it as a stream of word pairs under a valid/ready handshake, oldest word first. It is the reading end of the pair-packing window buffer and feeds downstream serial consumers such as the UART/debug link or a pairwise NN input stage.

---
 rtl/ap_parameters.sv | 21 ++
 rtl/feature_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ap_parameters.sv
// ---------------------------------------------------------------------------
// ap_parameters
// Shared parameters and types for the audio-processing feature path.
//   NN_DATA_WIDTH  : width of one feature word
//   NN_ARRAY_WIDTH : words per feature frame (even, <= 32)
//   NN_PAIR_BEATS  : word-pair beats needed to stream one frame
//   fs_state_t     : feature_serializer FSM states
// ---------------------------------------------------------------------------
package ap_parameters;

    localparam int NN_DATA_WIDTH  = 16;
    localparam int NN_ARRAY_WIDTH = 26;
    localparam int NN_PAIR_BEATS  = NN_ARRAY_WIDTH / 2;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_SEND,
        FS_CSUM
    } fs_state_t;

endpackage

// File: rtl/feature_serializer.sv
// ---------------------------------------------------------------------------
// feature_serializer
// Captures one parallel feature frame and streams it out as word pairs,
// oldest word first, under a valid/ready handshake.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   load_valid/load_ready  frame capture handshake (ready only when idle)
//   data_in                parallel frame, ARRAY_WIDTH words
//   start_idx              index of the oldest word in data_in
//   out_valid/out_ready    pair stream handshake
//   data_out1/data_out2    older/newer word of the current pair
//   out_last               final beat of the frame
//   busy                   a frame is held (FSM not idle)
//
// Configuration
//   FEATURE_SERIALIZER_CHECKSUM_EN : when defined, a trailing beat carries
//   the running sum (data_out1) and running XOR (data_out2) of all words,
//   and out_last moves from the final data beat to that checksum beat.
// ---------------------------------------------------------------------------
module feature_serializer
    import ap_parameters::*;
#(
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int ARRAY_WIDTH = NN_ARRAY_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] data_in,
    input  logic [4:0]                            start_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 data_out1,
    output logic [DATA_WIDTH-1:0]                 data_out2,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam logic [5:0] AW6    = 6'(ARRAY_WIDTH);
    localparam logic [4:0] LAST_K = 5'(ARRAY_WIDTH / 2 - 1);

    // Index arithmetic never exceeds 2*ARRAY_WIDTH-1, so a single
    // conditional subtract is enough to bring it back into the frame.
    function automatic logic [4:0] wrap_idx(input logic [5:0] v);
        return 5'((v >= AW6) ? v - AW6 : v);
    endfunction

    fs_state_t                              state_q, state_d;
    logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] frame_q, frame_d;
    logic [4:0]                             base_q, base_d;
    logic [4:0]                             k_q, k_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]                  data_out1_q, data_out1_d;
    logic [DATA_WIDTH-1:0]                  data_out2_q, data_out2_d;
    logic                                   load_ready_q, load_ready_d;
    logic                                   busy_q, busy_d;

    logic [4:0] nxt_k;
    logic [4:0] idx0, idx1;
    logic [4:0] ld_base, ld_idx1;

`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d, xor_q, xor_d;
    logic [DATA_WIDTH-1:0] sum_nx, xor_nx;
`endif

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        base_d      = base_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        data_out1_d = data_out1_q;
        data_out2_d = data_out2_q;
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
        sum_d  = sum_q;
        xor_d  = xor_q;
        // Totals including the pair currently on the outputs.
        sum_nx = sum_q + data_out1_q + data_out2_q;
        xor_nx = xor_q ^ data_out1_q ^ data_out2_q;
`endif

        // Read addresses of the beat that follows the one being presented.
        nxt_k = k_q + 5'd1;
        idx0  = wrap_idx({1'b0, base_q} + {nxt_k, 1'b0});
        idx1  = wrap_idx({1'b0, idx0} + 6'd1);

        // Out-of-range start indices fall back to word 0.
        ld_base = ({1'b0, start_idx} >= AW6) ? 5'd0 : start_idx;
        ld_idx1 = wrap_idx({1'b0, ld_base} + 6'd1);

        case (state_q)
            FS_IDLE: begin
                if (load_valid) begin
                    frame_d     = data_in;
                    base_d      = ld_base;
                    k_d         = 5'd0;
                    out_valid_d = 1'b1;
                    data_out1_d = data_in[ld_base];
                    data_out2_d = data_in[ld_idx1];
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
                    out_last_d  = 1'b0;
                    sum_d       = '0;
                    xor_d       = '0;
`else
                    out_last_d  = (LAST_K == 5'd0);
`endif
                    state_d     = FS_SEND;
                end
            end

            FS_SEND: begin
                if (out_ready) begin
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
                    sum_d = sum_nx;
                    xor_d = xor_nx;
`endif
                    if (k_q == LAST_K) begin
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
                        data_out1_d = sum_nx;
                        data_out2_d = xor_nx;
                        out_last_d  = 1'b1;
                        state_d     = FS_CSUM;
`else
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = FS_IDLE;
`endif
                    end else begin
                        k_d         = nxt_k;
                        data_out1_d = frame_q[idx0];
                        data_out2_d = frame_q[idx1];
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
                        out_last_d  = 1'b0;
`else
                        out_last_d  = (nxt_k == LAST_K);
`endif
                    end
                end
            end

`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
            FS_CSUM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = FS_IDLE;
                end
            end
`endif

            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = FS_IDLE;
            end
        endcase

        // Handshake flags are registered straight from the next state.
        load_ready_d = (state_d == FS_IDLE);
        busy_d       = (state_d != FS_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_IDLE;
            base_q       <= '0;
            k_q          <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            data_out1_q  <= '0;
            data_out2_q  <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
            sum_q        <= '0;
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            k_q          <= k_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            data_out1_q  <= data_out1_d;
            data_out2_q  <= data_out2_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
`ifdef FEATURE_SERIALIZER_CHECKSUM_EN
            sum_q        <= sum_d;
            xor_q        <= xor_d;
`endif
        end
    end

    // Frame storage is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign data_out1  = data_out1_q;
    assign data_out2  = data_out2_q;

endmodule
